multiplier_control: RTL and testbench
=====================================

// Module: multiplier_control
// PURPOSE
//  Control FSM for the 8-bit signed add-shift multiplier datapath.
//  - Sequences clear, load and add/subtract/shift steps from the user run and load pushbuttons.
//  - Drives the datapath strobes shift, sub_add, ld_xa, ld_b and clr_xa.
//  - Samples the datapath multiplier LSB (m) to decide each add.
//  - Sits directly upstream of the datapath; one instance per multiplier.
// PARAMETERS
//  WIDTH    8                  operand width = number of add/shift iterations
//  CNT_W    $clog2(WIDTH)      iteration counter width (derived, not overridden)
// PORTS
//  clk              in   1      system clock; all state updates on posedge
//  reset            in   1      synchronous, active-high reset
//  run              in   1      start multiply (level; priority over clr_ld)
//  clr_ld           in   1      clear X:A and load B from switches
//  m                in   1      current multiplier LSB from datapath B register
//  shift            out  1      arithmetic right-shift X:A:B by one
//  sub_add          out  1      0 = A+S, 1 = A-S for the current ld_xa
//  ld_xa            out  1      load adder result into X:A
//  ld_b             out  1      load B from switches
//  clr_xa           out  1      clear X and A to 0
//  busy             out  1      multiply in progress
//  done             out  1      product valid in A:B
// BEHAVIOUR
//  - States: IDLE, LOADB, CLR, ADD, SHIFT, HOLD. The 3-bit counter cnt tracks the iteration, 0..WIDTH-1.
//  - Reset: state=IDLE, cnt=0, all outputs 0 in the following cycle.
//    Reset has priority over every input, including mid-multiply; the partial product is abandoned.
//  - IDLE: all outputs 0.
//    run=1 -> CLR. Else clr_ld=1 -> LOADB. Else stay.
//  - LOADB (1 cycle): clr_xa=1, ld_b=1 -> IDLE.
//  - CLR (1 cycle): clr_xa=1, busy=1, cnt<=0 -> ADD.
//  - ADD (1 cycle): busy=1, ld_xa=m (Mealy), sub_add=(cnt==WIDTH-1) -> SHIFT.
//    A subtract therefore happens only on the last iteration (sign bit of B).
//  - SHIFT (1 cycle): busy=1, shift=1.
//    cnt==WIDTH-1 -> HOLD. Else cnt<=cnt+1 -> ADD.
//  - HOLD: done=1. run=0 -> IDLE; otherwise stay.
//    HOLD lasts at least 1 cycle, and a held run never re-triggers.
//  - run or clr_ld changes during CLR/ADD/SHIFT are ignored.
//  - clr_ld in HOLD is ignored.
//  - Latency: run sampled high in IDLE at edge N gives the following sequence:
//    CLR at N+1, ADD/SHIFT pairs N+2..N+17, done=1 from N+18 (fixed, 2*WIDTH+2).
//  - At most one of shift / ld_xa / ld_b is high in any cycle. clr_xa and ld_b coincide only in LOADB.
// CONFIGURATION
//  - MULT_CTRL_SKIP_ZERO_EN defined: ADD with m=0 asserts shift=1 and ld_xa=0 and does not enter SHIFT.
//    It goes to HOLD if cnt==WIDTH-1, else cnt<=cnt+1 and stays in ADD.
//    Latency = 2 + WIDTH + popcount(B) cycles to done.
//  - Undefined: fixed 2-cycle iterations as above.
// STRUCTURE
//  - multiplier_pkg holds the following shared items:
//    typedef enum logic [2:0] mult_state_t {IDLE, LOADB, CLR, ADD, SHIFT, HOLD};
//    localparam MULT_WIDTH = 8.
//  - No sub-module: the counter and next-state logic are inline.
//    One always_ff handles state/cnt; one always_comb handles next-state and outputs.
// TESTING
//  - Bench: behavioural datapath model drives m from a shifting B. Check the product in A:B.
//  - reset=1 for 2 cycles mid-ADD at cnt=3 -> next cycle IDLE, all outputs 0, busy=0.
//  - clr_ld pulse, B=8'h05 -> one cycle with clr_xa=ld_b=1, then IDLE. No shift.
//  - S=8'h07, B=8'h05, run held -> done at N+18 with A:B=16'h0023. sub_add never asserted with ld_xa.
//  - S=8'h03, B=8'hFE (-2) -> ld_xa with sub_add=1 at cnt=7. Product 16'hFFFA.
//  - Hold run for 40 cycles after done -> stays HOLD with no restart.
//    Release run -> IDLE next cycle. Reassert run -> new CLR.
//  - SKIP_ZERO build, B=8'h00 -> done at N+10, zero ld_xa pulses.
//    B=8'hFF -> done at N+18, product matches the default build.

Source files
------------

// File: rtl/multiplier_pkg.sv
// ============================================================================
// Module  : multiplier_pkg
// Brief   : Shared state encoding and width for the add-shift multiplier.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package multiplier_pkg;

    // Operand width; also the number of add/shift iterations.
    localparam int MULT_WIDTH = 8;

    // Controller states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOADB = 3'd1,
        CLR   = 3'd2,
        ADD   = 3'd3,
        SHIFT = 3'd4,
        HOLD  = 3'd5
    } mult_state_t;

endpackage

`default_nettype wire

// File: rtl/multiplier_control.sv
// ============================================================================
// Module  : multiplier_control
// Brief   : Control FSM for the 8-bit signed add-shift multiplier datapath.
//           Sequences clear, load and add/subtract/shift steps from the run
//           and clr_ld buttons and samples the multiplier LSB (m).
//           Optional build macro MULT_CTRL_SKIP_ZERO_EN: an ADD step with
//           m=0 shifts immediately instead of spending a separate SHIFT cycle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module multiplier_control
    import multiplier_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clr_ld,
    input  logic m,
    output logic shift,
    output logic sub_add,
    output logic ld_xa,
    output logic ld_b,
    output logic clr_xa,
    output logic busy,
    output logic done
);

    localparam int               CNT_W  = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    mult_state_t      r_state;
    mult_state_t      w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_last;

    assign w_last = (r_cnt == c_LAST);

    // State and iteration counter register; reset abandons any multiply.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state, counter update and strobe decode (ld_xa is Mealy on m).
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        shift      = 1'b0;
        sub_add    = 1'b0;
        ld_xa      = 1'b0;
        ld_b       = 1'b0;
        clr_xa     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (run) begin
                    w_next = CLR;
                end else if (clr_ld) begin
                    w_next = LOADB;
                end
            end
            LOADB: begin
                clr_xa = 1'b1;
                ld_b   = 1'b1;
                w_next = IDLE;
            end
            CLR: begin
                clr_xa     = 1'b1;
                busy       = 1'b1;
                w_cnt_next = '0;
                w_next     = ADD;
            end
            ADD: begin
                busy    = 1'b1;
                // Only the sign bit of B (last iteration) carries negative weight.
                sub_add = w_last;
`ifdef MULT_CTRL_SKIP_ZERO_EN
                if (m) begin
                    ld_xa  = 1'b1;
                    w_next = SHIFT;
                end else begin
                    shift = 1'b1;
                    if (w_last) begin
                        w_next = HOLD;
                    end else begin
                        w_cnt_next = r_cnt + c_ONE;
                    end
                end
`else
                ld_xa  = m;
                w_next = SHIFT;
`endif
            end
            SHIFT: begin
                busy  = 1'b1;
                shift = 1'b1;
                if (w_last) begin
                    w_next = HOLD;
                end else begin
                    w_cnt_next = r_cnt + c_ONE;
                    w_next     = ADD;
                end
            end
            HOLD: begin
                // A held run button must be released before a new multiply.
                done = 1'b1;
                if (!run) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_multiplier_control.sv
// ============================================================================
// Module  : tb_multiplier_control
// Brief   : Directed bench for multiplier_control with a behavioural X:A:B
//           datapath model feeding m. Honours MULT_CTRL_SKIP_ZERO_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multiplier_control;

`ifdef MULT_CTRL_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    // Output vector layout: {shift, sub_add, ld_xa, ld_b, clr_xa, busy, done}
    localparam logic [6:0] c_O_IDLE  = 7'b0000000;
    localparam logic [6:0] c_O_LOADB = 7'b0001100;
    localparam logic [6:0] c_O_CLR   = 7'b0000110;
    localparam logic [6:0] c_O_HOLD  = 7'b0000001;

    logic clk = 1'b0;
    logic reset, run, clr_ld, m;
    logic shift, sub_add, ld_xa, ld_b, clr_xa, busy, done;
    logic [6:0] w_outs;

    // Behavioural datapath
    logic       X;
    logic [7:0] A, B;
    logic [7:0] s_val, sw_b;
    logic [8:0] w_sum;

    int checks = 0;
    int errors = 0;

    multiplier_control dut (
        .clk     (clk),
        .reset   (reset),
        .run     (run),
        .clr_ld  (clr_ld),
        .m       (m),
        .shift   (shift),
        .sub_add (sub_add),
        .ld_xa   (ld_xa),
        .ld_b    (ld_b),
        .clr_xa  (clr_xa),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    assign w_outs = {shift, sub_add, ld_xa, ld_b, clr_xa, busy, done};
    assign m      = B[0];
    assign w_sum  = sub_add ? ({A[7], A} - {s_val[7], s_val})
                            : ({A[7], A} + {s_val[7], s_val});

    always @(posedge clk) begin
        if (clr_xa) begin
            X <= 1'b0;
            A <= 8'h00;
        end
        if (ld_b) B <= sw_b;
        if (ld_xa) begin
            X <= w_sum[8];
            A <= w_sum[7:0];
        end
        if (shift) begin
            A <= {X, A[7:1]};
            B <= {A[0], B[7:1]};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_b(input logic [7:0] b);
        sw_b   = b;
        clr_ld = 1'b1;
        tick();
        clr_ld = 1'b0;
        tick();
    endtask

    task automatic do_run(input string tag, input logic [7:0] s, input logic [7:0] b,
                          input int lat_exp, input logic [15:0] prod_exp,
                          input int ldxa_exp, input int subs_exp);
        int  lat, ldxa, subs, shifts, badsub;
        bit  seen;
        lat = 0; ldxa = 0; subs = 0; shifts = 0; badsub = 0; seen = 1'b0;
        s_val = s;
        load_b(b);
        run = 1'b1;
        for (int k = 1; k <= 60 && !seen; k++) begin
            tick();
            lat = k;
            if (done) begin
                seen = 1'b1;
            end else begin
                if (ld_xa) begin
                    ldxa++;
                    if (sub_add) begin
                        subs++;
                        if (shifts != 7) badsub++;
                    end
                end
                if (shift) shifts++;
            end
        end
        chk({tag, "_latency"}, lat, lat_exp);
        chk({tag, "_product"}, {A, B}, prod_exp);
        chk({tag, "_ldxa_cnt"}, ldxa, ldxa_exp);
        chk({tag, "_sub_cnt"}, subs, subs_exp);
        chk({tag, "_sub_iter"}, badsub, 0);
        run = 1'b0;
        tick();
        chk({tag, "_idle_after"}, w_outs, c_O_IDLE);
    endtask

    initial begin
        int  shifts;
        int  bad;
        reset = 1'b1; run = 1'b0; clr_ld = 1'b0; sw_b = 8'h00; s_val = 8'h00;
        tick();
        tick();
        reset = 1'b0;
        chk("reset_outs", w_outs, c_O_IDLE);
        tick();
        chk("idle_outs", w_outs, c_O_IDLE);

        // clr_ld pulse: one LOADB cycle, then back to IDLE
        sw_b   = 8'h05;
        clr_ld = 1'b1;
        tick();
        chk("loadb_outs", w_outs, c_O_LOADB);
        clr_ld = 1'b0;
        tick();
        chk("loadb_to_idle", w_outs, c_O_IDLE);
        chk("loadb_b_reg", B, 8'h05);

        // 7 * 5 = 35
        do_run("m7x5", 8'h07, 8'h05, SKIP ? 12 : 18, 16'h0023, 2, 0);

        // Held run after done: no restart, release -> IDLE, reassert -> CLR
        s_val = 8'h07;
        load_b(8'h05);
        run = 1'b1;
        for (int k = 0; k < 60 && !done; k++) tick();
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (w_outs !== c_O_HOLD) bad++;
        end
        chk("hold_40", bad, 0);
        run = 1'b0;
        tick();
        chk("hold_release_idle", w_outs, c_O_IDLE);
        run = 1'b1;
        tick();
        chk("rerun_clr", w_outs, c_O_CLR);
        run = 1'b0;

        // Reset in ADD at cnt=3: restart the multiply with B=FE, stop after 3 shifts
        load_b(8'hFE);
        run = 1'b1;
        tick();
        run = 1'b0;
        shifts = 0;
        for (int k = 0; k < 30 && shifts < 3; k++) begin
            if (shift) shifts++;
            tick();
        end
        chk("pre_reset_busy", {busy, shift & ~SKIP}, 2'b10);
        reset = 1'b1;
        tick();
        chk("mid_reset_outs", w_outs, c_O_IDLE);
        tick();
        reset = 1'b0;
        tick();
        chk("post_reset_idle", w_outs, c_O_IDLE);

        // 3 * -2 = -6; the only subtract is on the sign-bit iteration
        do_run("m3xFE", 8'h03, 8'hFE, SKIP ? 17 : 18, 16'hFFFA, 7, 1);
        // 7 * 0 = 0
        do_run("m7x00", 8'h07, 8'h00, SKIP ? 10 : 18, 16'h0000, 0, 0);
        // 3 * -1 = -3
        do_run("m3xFF", 8'h03, 8'hFF, 18, 16'hFFFD, 8, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
